// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory answering the controller's readmem/writemem
//   interface with a fixed multi-cycle access latency and a ready/busy
//   handshake. Requests are sampled only while idle; illegal requests
//   (read and write together, misaligned, out of range) are rejected with a
//   one-cycle err pulse. Array contents are not cleared by reset.
//
//   Ports
//     clk       in   rising-edge clock
//     rst       in   synchronous, active-high reset
//     readmem   in   load request
//     writemem  in   store request
//     addr      in   32-bit byte address
//     wdata     in   store data
//     rdata     out  load data, holds the last completed load
//     ready     out  one-cycle pulse: access complete
//     busy      out  high while an accepted access is in flight
//     err       out  one-cycle pulse: request rejected
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  readmem,
    input  logic                  writemem,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              cnt;
    logic                    op_write;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req;
    logic                    reject;
    logic                    accept;
    logic                    commit;
    logic                    c_write;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [DATA_WIDTH-1:0]   c_wdata;

    always_comb begin
        req    = readmem | writemem;
        reject = (readmem && writemem)
              || (addr[1:0] != 2'b00)
              || (addr[31:ADDR_WIDTH+2] != '0);
        accept = (state == IDLE) && req && !reject;
        commit = (next_state == DONE) && (state != DONE);
        // With LATENCY==1 the DONE-entry edge is the accept edge itself, so
        // the commit must use the live request rather than the latched copy.
        if (state == IDLE) begin
            c_write = writemem;
            c_idx   = addr[ADDR_WIDTH+1:2];
            c_wdata = wdata;
        end else begin
            c_write = op_write;
            c_idx   = idx;
            c_wdata = wdata_q;
        end
    end

    // State register, counter, err and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            err_q <= (state == IDLE) && req && reject;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !c_write) begin
                rdata_q <= mem[c_idx];
            end
        end
    end

    // Request capture; no reset needed, only meaningful after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= writemem;
            idx      <= addr[ADDR_WIDTH+1:2];
            wdata_q  <= wdata;
        end
    end

    // Storage array; reset suppresses a commit on the same edge
    always_ff @(posedge clk) begin
        if (!rst && commit && c_write) begin
            mem[c_idx] <= c_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (LATENCY == 1) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd1) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        err   = err_q;
        rdata = rdata_q;
        unique case (state)
            ACCESS:  busy = 1'b1;
            DONE: begin
                busy  = 1'b1;
                ready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
